// File: rtl/mcm_pack_param.sv
// mcm_pack_param
// Reads a frame of NBYTES bytes from MCM RAM after a rising edge of the
// coordinator done signal. It packs the bytes MSB-first into OUT_W-bit orbit
// words, or in raw mode passes each byte through zero-extended. The words are
// written to the group distributor starting at a latched base address.
//
// Ports:
//   clk, reset        clock, asynchronous active-low reset
//   iDone             coordinator done; a rising edge starts a frame
//   iMode, iWrBase    packed/raw select and first write address, latched at start
//   iData             RAM read data, valid RD_LAT cycles after oRdEn
//   oRdAddr, oRdEn    RAM read address and enable
//   iBusy             LCB busy; stalls RAM reads and distributor writes
//   oData, oAddr      orbit word and distributor address
//   oWren             distributor write strobe
//   oBusy             frame in progress
//   oFrameDone        one-cycle pulse at end of frame
//   oOverrun          one-cycle pulse when a start edge arrives mid-frame
module mcm_pack_param #(
  parameter int IN_W   = 8,
  parameter int OUT_W  = 12,
  parameter int RD_AW  = 8,
  parameter int WR_AW  = 10,
  parameter int NBYTES = 192,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iDone,
  input  logic             iMode,
  input  logic [WR_AW-1:0] iWrBase,
  input  logic [IN_W-1:0]  iData,
  output logic [RD_AW-1:0] oRdAddr,
  output logic             oRdEn,
  input  logic             iBusy,
  output logic [OUT_W-1:0] oData,
  output logic [WR_AW-1:0] oAddr,
  output logic             oWren,
  output logic             oBusy,
  output logic             oFrameDone,
  output logic             oOverrun
);

  localparam int ACC_W = OUT_W + IN_W - 1;
  localparam int CW    = $clog2(ACC_W + 1);
  localparam int BW    = RD_AW + 1;
  localparam logic [CW-1:0] OUT_W_C  = CW'(OUT_W);
  localparam logic [CW-1:0] IN_W_C   = CW'(IN_W);
  localparam logic [BW-1:0] NBYTES_C = BW'(NBYTES);
  // Last value of the LAT wait counter; unused when RD_LAT is 1.
  localparam logic [3:0]    LAT_LAST = 4'(RD_LAT - 2);

  typedef enum logic [2:0] {S_IDLE, S_RD, S_LAT, S_CAP, S_WR, S_FLUSH, S_FIN} state_t;

  // The valid bits sit in acc[cnt-1:0], oldest bit highest. A full word is the
  // top OUT_W of them.
  function automatic logic [OUT_W-1:0] top_word(input logic [ACC_W-1:0] acc,
                                                input logic [CW-1:0] cnt);
    logic [ACC_W-1:0] sh;
    sh = acc >> (cnt - OUT_W_C);
    return sh[OUT_W-1:0];
  endfunction

  // The residual bits (cnt < OUT_W) are moved to the MSB end of the word, and the
  // LSBs are zero-filled.
  function automatic logic [OUT_W-1:0] flush_word(input logic [ACC_W-1:0] acc,
                                                  input logic [CW-1:0] cnt);
    logic [ACC_W-1:0] sh;
    sh = acc << (OUT_W_C - cnt);
    return sh[OUT_W-1:0];
  endfunction

  state_t           state_q, state_d;
  logic             done_q, done_d;
  logic             mode_q, mode_d;
  logic [WR_AW-1:0] base_q, base_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [BW-1:0]    byte_q, byte_d;
  logic [WR_AW-1:0] widx_q, widx_d;
  logic [3:0]       lat_q, lat_d;
  logic [RD_AW-1:0] rd_addr_q, rd_addr_d;
  logic [OUT_W-1:0] data_q, data_d;
  logic [WR_AW-1:0] addr_q, addr_d;
  logic             busy_q, busy_d;
  logic             fd_q, fd_d;
  logic             ovr_q, ovr_d;

  logic             rise;
  logic [ACC_W-1:0] acc_n;
  logic [CW-1:0]    cnt_n;
  logic [BW-1:0]    next_byte;

  // Next-state and datapath logic for the frame sequencer.
  always_comb begin
    state_d   = state_q;
    done_d    = iDone;
    mode_d    = mode_q;
    base_d    = base_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    byte_d    = byte_q;
    widx_d    = widx_q;
    lat_d     = lat_q;
    rd_addr_d = rd_addr_q;
    data_d    = data_q;
    addr_d    = addr_q;
    rise      = iDone && !done_q;
    acc_n     = (acc_q << IN_W) | ACC_W'(iData);
    cnt_n     = cnt_q + IN_W_C;
    next_byte = byte_q + BW'(1);

    case (state_q)
      S_IDLE: begin
        if (rise) begin
          mode_d    = iMode;
          base_d    = iWrBase;
          acc_d     = '0;
          cnt_d     = '0;
          byte_d    = '0;
          widx_d    = '0;
          rd_addr_d = '0;
          state_d   = S_RD;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RD: begin
        if (!iBusy) begin
          lat_d   = '0;
          state_d = (RD_LAT > 1) ? S_LAT : S_CAP;
        end else begin
          state_d = S_RD;
        end
      end
      S_LAT: begin
        if (lat_q == LAT_LAST) begin
          state_d = S_CAP;
        end else begin
          lat_d = lat_q + 4'd1;
        end
      end
      S_CAP: begin
        byte_d = next_byte;
        if (mode_q) begin
          data_d  = OUT_W'(iData);
          addr_d  = base_q + widx_q;
          state_d = S_WR;
        end else if (cnt_n >= OUT_W_C) begin
          acc_d   = acc_n;
          data_d  = top_word(acc_n, cnt_n);
          cnt_d   = cnt_n - OUT_W_C;
          addr_d  = base_q + widx_q;
          state_d = S_WR;
        end else begin
          acc_d = acc_n;
          cnt_d = cnt_n;
          if (next_byte < NBYTES_C) begin
            rd_addr_d = next_byte[RD_AW-1:0];
            state_d   = S_RD;
          end else begin
            state_d = S_FLUSH;
          end
        end
      end
      S_WR: begin
        // oData/oAddr are loaded on entry, so they stay stable through a stall.
        if (!iBusy) begin
          widx_d = widx_q + WR_AW'(1);
          if (cnt_q >= OUT_W_C) begin
            data_d = top_word(acc_q, cnt_q);
            cnt_d  = cnt_q - OUT_W_C;
            addr_d = base_q + widx_q + WR_AW'(1);
          end else if (byte_q < NBYTES_C) begin
            rd_addr_d = byte_q[RD_AW-1:0];
            state_d   = S_RD;
          end else begin
            state_d = S_FLUSH;
          end
        end else begin
          state_d = S_WR;
        end
      end
      S_FLUSH: begin
        // The partial word goes through WR; WR returns here with cnt == 0.
        if (cnt_q != '0) begin
          data_d  = flush_word(acc_q, cnt_q);
          cnt_d   = '0;
          addr_d  = base_q + widx_q;
          state_d = S_WR;
        end else begin
          state_d = S_FIN;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ovr_d  = rise && (state_q != S_IDLE);
    busy_d = (state_d != S_IDLE);
    fd_d   = (state_d == S_FIN);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      done_q    <= 1'b0;
      mode_q    <= 1'b0;
      base_q    <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      byte_q    <= '0;
      widx_q    <= '0;
      lat_q     <= '0;
      rd_addr_q <= '0;
      data_q    <= '0;
      addr_q    <= '0;
      busy_q    <= 1'b0;
      fd_q      <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      done_q    <= done_d;
      mode_q    <= mode_d;
      base_q    <= base_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      byte_q    <= byte_d;
      widx_q    <= widx_d;
      lat_q     <= lat_d;
      rd_addr_q <= rd_addr_d;
      data_q    <= data_d;
      addr_q    <= addr_d;
      busy_q    <= busy_d;
      fd_q      <= fd_d;
      ovr_q     <= ovr_d;
    end
  end

  // Strobes are decoded from the state register. They are gated with iBusy in
  // the same cycle, so a busy that rises on the strobe cycle still blocks it.
  assign oRdEn      = (state_q == S_RD) && !iBusy;
  assign oWren      = (state_q == S_WR) && !iBusy;
  assign oRdAddr    = rd_addr_q;
  assign oData      = data_q;
  assign oAddr      = addr_q;
  assign oBusy      = busy_q;
  assign oFrameDone = fd_q;
  assign oOverrun   = ovr_q;

endmodule

// File: tb/tb_mcm_pack_param.sv
// Self-checking bench for mcm_pack_param. Five instances cover small frames
// (NBYTES 3, 2, 4) and the default 192-byte frame with RD_LAT 1 and 2.
module tb_mcm_pack_param;

  localparam int NI = 5;
  localparam int NB_P  [NI] = '{3, 2, 4, 192, 192};
  localparam int LAT_P [NI] = '{1, 1, 1, 1, 2};

  logic       clk;
  logic       rst_n;
  logic       done_r [NI];
  logic       mode_r [NI];
  logic [9:0] base_r [NI];
  logic       busy_m [NI];
  logic       busy_rnd [NI];
  logic       rnd_en;
  logic       ibusy [NI];
  logic [7:0] idata [NI];
  logic [7:0] rdaddr [NI];
  logic       rden [NI];
  logic       wren [NI];
  logic       obusy [NI];
  logic       ofd [NI];
  logic       oovr [NI];
  logic [11:0] odata [NI];
  logic [9:0]  oaddr [NI];

  logic [7:0] ram [NI][256];
  logic [7:0] p1 [NI];
  logic [7:0] p2 [NI];

  int          wcnt [NI];
  int          fcnt [NI];
  int          ocnt [NI];
  int          vcnt [NI];
  bit          fd_prev [NI];
  logic [11:0] wd [NI][1024];
  logic [9:0]  wa [NI][1024];

  int          total;
  int          bad;
  logic [11:0] exp_d [256];
  logic [9:0]  exp_a [256];
  int          exp_n;

  typedef struct packed {
    int              inst;
    logic            mode;
    logic [9:0]      base;
    int              nw;
    logic [3:0][7:0]  bytes;
    logic [3:0][11:0] ed;
    logic [3:0][9:0]  ea;
  } vec_t;
  vec_t vecs [5];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    assign ibusy[gi] = busy_m[gi] | busy_rnd[gi];
    assign idata[gi] = (LAT_P[gi] == 2) ? p2[gi] : p1[gi];
    mcm_pack_param #(.NBYTES(NB_P[gi]), .RD_LAT(LAT_P[gi])) u_dut (
      .clk(clk), .reset(rst_n), .iDone(done_r[gi]), .iMode(mode_r[gi]),
      .iWrBase(base_r[gi]), .iData(idata[gi]), .oRdAddr(rdaddr[gi]),
      .oRdEn(rden[gi]), .iBusy(ibusy[gi]), .oData(odata[gi]), .oAddr(oaddr[gi]),
      .oWren(wren[gi]), .oBusy(obusy[gi]), .oFrameDone(ofd[gi]), .oOverrun(oovr[gi])
    );
  end

  always #5 clk = ~clk;

  // RAM with one or two cycles of read latency after oRdEn.
  always @(posedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (rden[g]) p1[g] <= ram[g][rdaddr[g]];
      p2[g] <= p1[g];
    end
  end

  // Capture writes and pulses, and count protocol violations.
  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if ((rden[g] && (wren[g] || ibusy[g])) || (wren[g] && ibusy[g]) ||
          (fd_prev[g] && obusy[g]) || (ofd[g] && !obusy[g]))
        vcnt[g] <= vcnt[g] + 1;
      fd_prev[g] <= ofd[g];
      if (wren[g]) begin
        wd[g][wcnt[g] % 1024] <= odata[g];
        wa[g][wcnt[g] % 1024] <= oaddr[g];
        wcnt[g] <= wcnt[g] + 1;
      end
      if (ofd[g]) fcnt[g] <= fcnt[g] + 1;
      if (oovr[g]) ocnt[g] <= ocnt[g] + 1;
    end
  end

  // Random LCB busy for the large instances.
  initial begin
    for (int g = 0; g < NI; g++) busy_rnd[g] = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      for (int g = 3; g < NI; g++) busy_rnd[g] = rnd_en && ($urandom_range(0, 3) == 0);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_frame(input int g);
    done_r[g] = 1'b1;
    step(1);
    chk($sformatf("busy_rise%0d", g), obusy[g], 1);
    step(1);
    done_r[g] = 1'b0;
  endtask

  task automatic wait_fd(input int g, input int f0);
    int n;
    n = 0;
    while (fcnt[g] == f0 && n < 6000) begin
      step(1);
      n++;
    end
    if (n >= 6000) begin
      total++;
      bad++;
      $display("FAIL timeout inst%0d: no frame done after %0d cycles", g, n);
    end
    step(3);
  endtask

  // Reference words: the frame is a bitstream of bytes, MSB first, cut into
  // 12-bit words with zero padding; raw mode maps each byte to one word.
  task automatic model(input int g);
    int nb;
    int p;
    logic [11:0] w;
    nb = NB_P[g];
    if (mode_r[g]) begin
      exp_n = nb;
      for (int k = 0; k < nb; k++) exp_d[k] = {4'h0, ram[g][k]};
    end else begin
      exp_n = (nb * 8 + 11) / 12;
      for (int k = 0; k < exp_n; k++) begin
        w = 12'h000;
        for (int j = 0; j < 12; j++) begin
          p = k * 12 + j;
          w = {w[10:0], (p < nb * 8) ? ram[g][p / 8][7 - (p % 8)] : 1'b0};
        end
        exp_d[k] = w;
      end
    end
    for (int k = 0; k < exp_n; k++) exp_a[k] = base_r[g] + 10'(k);
  endtask

  task automatic check_model(input int g, input int w0, input int f0, input int v0,
                             input string tag);
    model(g);
    chk({tag, "_count"}, wcnt[g] - w0, exp_n);
    for (int k = 0; k < exp_n && k < wcnt[g] - w0; k++) begin
      chk($sformatf("%s_data%0d", tag, k), wd[g][(w0 + k) % 1024], exp_d[k]);
      chk($sformatf("%s_addr%0d", tag, k), wa[g][(w0 + k) % 1024], exp_a[k]);
    end
    chk({tag, "_fdone"}, fcnt[g] - f0, 1);
    chk({tag, "_viol"}, vcnt[g] - v0, 0);
  endtask

  initial begin
    int g, w0, f0, v0, o0, found;
    logic [11:0] d0;
    logic [9:0]  a0;
    int serr;
    clk = 1'b0;
    rst_n = 1'b0;
    rnd_en = 1'b0;
    total = 0;
    bad = 0;
    for (int i = 0; i < NI; i++) begin
      done_r[i] = 1'b0; mode_r[i] = 1'b0; base_r[i] = '0; busy_m[i] = 1'b0;
    end

    vecs[0] = '{inst: 0, mode: 1'b0, base: 10'h010, nw: 2,
                bytes: {8'h00, 8'h56, 8'h34, 8'h12},
                ed: {12'h0, 12'h0, 12'h456, 12'h123}, ea: {10'h0, 10'h0, 10'h011, 10'h010}};
    vecs[1] = '{inst: 1, mode: 1'b0, base: 10'h155, nw: 2,
                bytes: {8'h00, 8'h00, 8'hCD, 8'hAB},
                ed: {12'h0, 12'h0, 12'hD00, 12'hABC}, ea: {10'h0, 10'h0, 10'h156, 10'h155}};
    vecs[2] = '{inst: 2, mode: 1'b1, base: 10'h3FE, nw: 4,
                bytes: {8'h00, 8'h80, 8'hFF, 8'h01},
                ed: {12'h000, 12'h080, 12'h0FF, 12'h001}, ea: {10'h001, 10'h000, 10'h3FF, 10'h3FE}};
    vecs[3] = '{inst: 2, mode: 1'b0, base: 10'h3FF, nw: 3,
                bytes: {8'h00, 8'h80, 8'hFF, 8'h01},
                ed: {12'h0, 12'h000, 12'hF80, 12'h01F}, ea: {10'h0, 10'h001, 10'h000, 10'h3FF}};
    vecs[4] = '{inst: 0, mode: 1'b1, base: 10'h200, nw: 3,
                bytes: {8'h00, 8'h56, 8'h34, 8'h12},
                ed: {12'h0, 12'h056, 12'h034, 12'h012}, ea: {10'h0, 10'h202, 10'h201, 10'h200}};

    // Reset state.
    #12;
    for (int i = 0; i < NI; i++)
      chk($sformatf("reset_outs%0d", i),
          {rden[i], wren[i], obusy[i], ofd[i], oovr[i], odata[i], oaddr[i], rdaddr[i]}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(2);

    // Table of small frames.
    for (int v = 0; v < 5; v++) begin
      g = vecs[v].inst;
      for (int i = 0; i < NB_P[g]; i++) ram[g][i] = vecs[v].bytes[i];
      mode_r[g] = vecs[v].mode;
      base_r[g] = vecs[v].base;
      w0 = wcnt[g]; f0 = fcnt[g]; v0 = vcnt[g];
      start_frame(g);
      wait_fd(g, f0);
      chk($sformatf("vec%0d_count", v), wcnt[g] - w0, vecs[v].nw);
      for (int k = 0; k < vecs[v].nw; k++) begin
        chk($sformatf("vec%0d_data%0d", v, k), wd[g][(w0 + k) % 1024], vecs[v].ed[k]);
        chk($sformatf("vec%0d_addr%0d", v, k), wa[g][(w0 + k) % 1024], vecs[v].ea[k]);
      end
      chk($sformatf("vec%0d_fdone", v), fcnt[g] - f0, 1);
      chk($sformatf("vec%0d_viol", v), vcnt[g] - v0, 0);
    end

    // Busy held for 10 cycles from the cycle WR is entered.
    ram[0][0] = 8'h12; ram[0][1] = 8'h34; ram[0][2] = 8'h56;
    mode_r[0] = 1'b0; base_r[0] = 10'h0A0;
    w0 = wcnt[0]; f0 = fcnt[0]; v0 = vcnt[0];
    start_frame(0);
    found = 0;
    for (int n = 0; n < 100 && found == 0; n++) begin
      @(negedge clk);
      if (rden[0] && rdaddr[0] == 8'd1) found = 1;
    end
    chk("stall_find", found, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    busy_m[0] = 1'b1;
    @(negedge clk);
    d0 = odata[0];
    a0 = oaddr[0];
    serr = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) @(negedge clk);
      if (wren[0] || rden[0] || odata[0] !== d0 || oaddr[0] !== a0) serr++;
    end
    chk("stall_quiet", serr, 0);
    chk("stall_data", d0, 12'h123);
    @(posedge clk);
    #1;
    busy_m[0] = 1'b0;
    @(negedge clk);
    chk("stall_release_wren", wren[0], 1);
    chk("stall_release_word", {odata[0], oaddr[0]}, {12'h123, 10'h0A0});
    wait_fd(0, f0);
    check_model(0, w0, f0, v0, "stall");

    // 192-byte incrementing frame with a second start edge mid-frame.
    for (int i = 0; i < 192; i++) begin
      ram[3][i] = 8'(i);
      ram[4][i] = 8'(i);
    end
    mode_r[3] = 1'b0; base_r[3] = 10'h3C0;
    w0 = wcnt[3]; f0 = fcnt[3]; v0 = vcnt[3]; o0 = ocnt[3];
    start_frame(3);
    step(40);
    done_r[3] = 1'b1;
    step(2);
    done_r[3] = 1'b0;
    wait_fd(3, f0);
    chk("overrun_pulses", ocnt[3] - o0, 1);
    chk("incr_words128", wcnt[3] - w0, 128);
    check_model(3, w0, f0, v0, "incr_lat1");

    mode_r[4] = 1'b0; base_r[4] = 10'h3C0;
    w0 = wcnt[4]; f0 = fcnt[4]; v0 = vcnt[4];
    start_frame(4);
    wait_fd(4, f0);
    chk("incr2_words128", wcnt[4] - w0, 128);
    check_model(4, w0, f0, v0, "incr_lat2");

    // Reset mid-frame, then a full frame.
    f0 = fcnt[3];
    start_frame(3);
    step(60);
    #2;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_outs",
        {rden[3], wren[3], obusy[3], ofd[3], oovr[3], odata[3], oaddr[3], rdaddr[3]}, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(3);
    chk("reset_mid_nodone", fcnt[3] - f0, 0);
    for (int i = 0; i < 192; i++) ram[3][i] = 8'($urandom);
    base_r[3] = 10'($urandom);
    w0 = wcnt[3]; f0 = fcnt[3]; v0 = vcnt[3];
    start_frame(3);
    wait_fd(3, f0);
    check_model(3, w0, f0, v0, "after_reset");

    // Random frames with random LCB busy.
    rnd_en = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int gg = 3; gg < NI; gg++) begin
        for (int i = 0; i < 192; i++) ram[gg][i] = 8'($urandom);
        mode_r[gg] = 1'($urandom);
        base_r[gg] = 10'($urandom);
        w0 = wcnt[gg]; f0 = fcnt[gg]; v0 = vcnt[gg];
        start_frame(gg);
        wait_fd(gg, f0);
        check_model(gg, w0, f0, v0, $sformatf("rand%0d_inst%0d", r, gg));
      end
    end
    rnd_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mcm_pack_param.md
Name: mcm_pack_param

Overview:
- Parametrised successor of the MCM packer.
- After the coordinator's done event, reads a frame of NBYTES bytes from MCM RAM. Packs them MSB-first into OUT_W-bit orbit words, or passes them through zero-extended in raw mode.
- Writes the words to the group distributor from a latched base address, stalling whenever the LCBs report busy.
- Reports its own busy, completion and overrun status.

Parameters:
- IN_W, 8: RAM data width.
- OUT_W, 12: orbit word width. Must be >= IN_W.
- RD_AW, 8: RAM read address width.
- WR_AW, 10: distributor address width. Addresses wrap mod 2^WR_AW.
- NBYTES, 192: bytes read per frame, 1..2^RD_AW.
- RD_LAT, 1: RAM read latency in cycles (1 or 2).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- iDone  in  1  coordinator done; a rising edge starts a frame.
- iMode  in  1  0 = packed, 1 = raw. Latched at start.
- iWrBase  in  WR_AW  first distributor address. Latched at start.
- iData  in  IN_W  RAM read data.
- oRdAddr  out  RD_AW  RAM read address.
- oRdEn  out  1  RAM read enable.
- iBusy  in  1  LCB busy; stalls reads and writes.
- oData  out  OUT_W  orbit word.
- oAddr  out  WR_AW  distributor address.
- oWren  out  1  distributor write strobe.
- oBusy  out  1  packer active.
- oFrameDone  out  1  one-cycle pulse at end of frame.
- oOverrun  out  1  one-cycle pulse on a start edge while active.

Behaviour:
- Reset (reset=0, async): all outputs 0; state IDLE; accumulator, bit count, byte index, word index and the iDone edge register cleared. Reset mid-frame aborts without flushing.
- Start: a rising edge of iDone (registered iDone 0 -> 1) in IDLE latches iMode and iWrBase, clears the indices, and enters RD. oBusy=1 from the next cycle.
- A rising edge in any state other than IDLE is ignored and pulses oOverrun for 1 cycle. The frame is unaffected.
- FSM states: IDLE, RD, LAT, CAP, WR, FLUSH, FIN.
- RD:
  - If iBusy=1, hold with oRdEn=0.
  - Else oRdEn=1 for exactly one cycle with oRdAddr = byte index, then go to LAT. oRdAddr holds its value afterwards.
- LAT: wait RD_LAT-1 cycles; zero cycles when RD_LAT=1. Go to CAP.
- CAP: iData is valid this cycle and is sampled at the end of CAP.
  - Packed mode: shift iData into the low end of the accumulator (acc = acc<<IN_W | iData) and add IN_W to the bit count.
  - Raw mode: word = zero-extended iData.
  - Byte index increments. Go to WR if a word is ready, else RD if bytes remain, else FLUSH.
- Word ready:
  - Packed mode: bit count >= OUT_W. The word is the top OUT_W valid bits and the bit count drops by OUT_W.
  - Raw mode: always ready.
- WR:
  - If iBusy=1, hold with oWren=0 and oData/oAddr unchanged.
  - Else oWren=1 for one cycle, oData = word, oAddr = (base + word index) mod 2^WR_AW. Word index increments.
  - Next state: WR again if another full word remains (packed, bit count still >= OUT_W), else RD if bytes remain, else FLUSH.
  - oData/oAddr hold after oWren falls.
- FLUSH:
  - If the residual bit count > 0, emit one word under the same iBusy rule as WR: residual bits left-justified (MSB-aligned), LSBs zero-filled.
  - Then go to FIN.
- FIN: oFrameDone=1 for one cycle, then IDLE with oBusy=0 on the following cycle.
- Words per frame: ceil(NBYTES*IN_W/OUT_W) in packed mode, NBYTES in raw mode.
- Accumulator width is OUT_W+IN_W-1 bits. Bit count never exceeds OUT_W+IN_W-1.
- Simultaneous events:
  - iBusy rising in the same cycle that WR would strobe blocks the strobe; iBusy is sampled combinationally in that cycle.
  - iBusy has no effect in IDLE, LAT, CAP or FIN.
- oRdEn and oWren are never high in the same cycle. No write is ever issued while iBusy=1.

Test Plan:
1. Packed, NBYTES=3, RAM = 0x12,0x34,0x56, base 0x010, iBusy=0 -> writes 0x123@0x010 and 0x456@0x011; oFrameDone pulses once; oBusy falls the cycle after.
2. Packed, NBYTES=2, RAM = 0xAB,0xCD -> writes 0xABC@base, then flush word 0xD00@base+1.
3. Raw, NBYTES=4, RAM = 0x01,0xFF,0x80,0x00, base 0x3FE -> writes 0x001@0x3FE, 0x0FF@0x3FF, 0x080@0x000, 0x000@0x001 (address wrap).
4. iBusy held high for 10 cycles starting at the cycle WR is entered -> oWren stays 0 with oData/oAddr stable throughout, and no oRdEn issues; the write occurs in the first cycle after iBusy=0.
5. Second iDone rising edge mid-frame -> one oOverrun pulse, frame completes unchanged. Async reset asserted mid-frame -> all outputs 0 immediately; a new iDone edge then runs a full correct frame.
6. Default params, 192 bytes of incrementing pattern -> exactly 128 writes at base..base+127, contents matching the MSB-first packed bitstream; RD_LAT=2 gives identical data.
